// File: rtl/norm_pkg.sv
// Shared definitions for the pipelined mantissa normalizer.
// Optional feature macro: NORM_UF_FLAG_EN (adds the out_uf exponent-clamp flag).
package norm_pkg;

    // Default widths matching the single-precision add/sub datapath
    localparam int EXP_W_D  = 8;
    localparam int MANT_W_D = 28;
    localparam int TAG_W_D  = 4;

    // Number of bits needed to encode values 0 .. value-1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Operand as carried through the stage registers at the default widths
    typedef struct packed {
        logic [EXP_W_D-1:0]  exp;
        logic [MANT_W_D-1:0] mant;
        logic [TAG_W_D-1:0]  tag;
    } norm_op_t;

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter for the normalizer.
// The mantissa is padded with zeros on the LSB side to a whole number of
// nibbles; padding never changes the count of a non-zero input because the
// leading one always lies in the real bits. An all-zero input reports 0
// with the zero flag raised. Macro NORM_UF_FLAG_EN does not affect this block.
module norm_lzc
    import norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_D,
    parameter int SH_W   = clog2(MANT_W + 1)
) (
    input  logic [MANT_W-1:0] mant,
    output logic [SH_W-1:0]   lzc,
    output logic              zero
);

    localparam int NIB   = (MANT_W + 3) / 4;
    localparam int PAD_W = NIB * 4;

    logic [PAD_W-1:0] mant_pad;
    logic [NIB-1:0]   nib_nz;
    logic [1:0]       nib_lz [NIB];

    assign mant_pad = PAD_W'(mant) << (PAD_W - MANT_W);
    assign zero     = ~|mant;

    // Per-nibble presence flag and 2-bit local leading-zero count
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
        logic [3:0] nib;
        assign nib        = mant_pad[gi*4 +: 4];
        assign nib_nz[gi] = |nib;
        assign nib_lz[gi] = nib[3] ? 2'd0 :
                            nib[2] ? 2'd1 :
                            nib[1] ? 2'd2 : 2'd3;
    end

    // Priority across nibbles: the highest non-zero nibble wins (scanned last)
    always_comb begin
        lzc = '0;
        for (int i = 0; i < NIB; i++) begin
            if (nib_nz[i]) begin
                lzc = SH_W'((NIB - 1 - i) * 4) + SH_W'(nib_lz[i]);
            end
        end
    end

endmodule

// File: rtl/normalize_pipe.sv
// Two-stage valid/ready mantissa normalizer.
// S1 registers the operand with its leading-zero count; S2 shifts the
// mantissa left and lowers the exponent, clamping at exponent 0 (denormal).
// Ready propagates combinationally back from out_ready (no skid buffer).
// Optional feature macro: NORM_UF_FLAG_EN adds the registered out_uf port.
module normalize_pipe
    import norm_pkg::*;
#(
    parameter int EXP_W  = EXP_W_D,
    parameter int MANT_W = MANT_W_D,
    parameter int TAG_W  = TAG_W_D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_zero
`ifdef NORM_UF_FLAG_EN
    ,
    output logic              out_uf
`endif
);

    localparam int SH_W  = clog2(MANT_W + 1);
    localparam int CMP_W = (EXP_W > SH_W) ? EXP_W : SH_W;

    // Stage register layout at this instance's widths (same shape as norm_op_t)
    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
        logic [TAG_W-1:0]  tag;
    } op_t;

    logic              s1_valid_q, s1_valid_d;
    op_t               s1_op_q, s1_op_d;
    logic [SH_W-1:0]   s1_lzc_q, s1_lzc_d;
    logic              s1_zero_q, s1_zero_d;

    logic              out_valid_q, out_valid_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic [MANT_W-1:0] out_mant_q, out_mant_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_zero_q, out_zero_d;
`ifdef NORM_UF_FLAG_EN
    logic              out_uf_q, out_uf_d;
    logic              norm_uf;
`endif

    logic              s1_en, s2_en, in_fire;
    logic [SH_W-1:0]   lzc_w;
    logic              zero_w;
    logic [EXP_W-1:0]  norm_exp;
    logic [MANT_W-1:0] norm_mant;
    logic [CMP_W-1:0]  exp_ext, lzc_ext;

    // Stage enables: a stage may load when it is empty or its content leaves
    assign s2_en    = !out_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;
    assign in_fire  = in_valid && s1_en;

    norm_lzc #(
        .MANT_W (MANT_W),
        .SH_W   (SH_W)
    ) u_lzc (
        .mant (in_mant),
        .lzc  (lzc_w),
        .zero (zero_w)
    );

    // S1 next state: capture operand and its leading-zero count on transfer
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_lzc_d   = s1_lzc_q;
        s1_zero_d  = s1_zero_q;
        if (s1_en) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            s1_op_d   = '{exp: in_exp, mant: in_mant, tag: in_tag};
            s1_lzc_d  = lzc_w;
            s1_zero_d = zero_w;
        end
    end

    assign exp_ext = CMP_W'(s1_op_q.exp);
    assign lzc_ext = CMP_W'(s1_lzc_q);

    // S2 datapath: full shift when the exponent allows it, else clamp at 0
    always_comb begin
        norm_exp  = s1_op_q.exp;
        norm_mant = s1_op_q.mant;
`ifdef NORM_UF_FLAG_EN
        norm_uf   = 1'b0;
`endif
        if (!s1_zero_q) begin
            if (exp_ext >= lzc_ext) begin
                // In this branch lzc fits in EXP_W bits, so the cast is lossless
                norm_mant = s1_op_q.mant << s1_lzc_q;
                norm_exp  = s1_op_q.exp - EXP_W'(s1_lzc_q);
            end else begin
                norm_mant = s1_op_q.mant << s1_op_q.exp;
                norm_exp  = '0;
`ifdef NORM_UF_FLAG_EN
                norm_uf   = 1'b1;
`endif
            end
        end
    end

    // S2 next state: advance S1 into the output register when allowed
    always_comb begin
        out_valid_d = out_valid_q;
        out_exp_d   = out_exp_q;
        out_mant_d  = out_mant_q;
        out_tag_d   = out_tag_q;
        out_zero_d  = out_zero_q;
`ifdef NORM_UF_FLAG_EN
        out_uf_d    = out_uf_q;
`endif
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_exp_d  = norm_exp;
                out_mant_d = norm_mant;
                out_tag_d  = s1_op_q.tag;
                out_zero_d = s1_zero_q;
`ifdef NORM_UF_FLAG_EN
                out_uf_d   = norm_uf;
`endif
            end
        end
    end

    // Pipeline registers; reset discards everything in flight immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_lzc_q    <= '0;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_exp_q   <= '0;
            out_mant_q  <= '0;
            out_tag_q   <= '0;
            out_zero_q  <= 1'b0;
`ifdef NORM_UF_FLAG_EN
            out_uf_q    <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_lzc_q    <= s1_lzc_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            out_exp_q   <= out_exp_d;
            out_mant_q  <= out_mant_d;
            out_tag_q   <= out_tag_d;
            out_zero_q  <= out_zero_d;
`ifdef NORM_UF_FLAG_EN
            out_uf_q    <= out_uf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_exp   = out_exp_q;
    assign out_mant  = out_mant_q;
    assign out_tag   = out_tag_q;
    assign out_zero  = out_zero_q;
`ifdef NORM_UF_FLAG_EN
    assign out_uf    = out_uf_q;
`endif

endmodule

// File: tb/tb_normalize_pipe.sv
// Self-checking bench for normalize_pipe (EXP_W=8, MANT_W=28, TAG_W=4).
// Expected results come from a behavioural normalizer model and a FIFO
// scoreboard; out_uf is checked only when NORM_UF_FLAG_EN is defined.
module tb_normalize_pipe;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 28;
    localparam int TAG_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
`ifdef NORM_UF_FLAG_EN
    logic              out_uf;
`endif

    normalize_pipe #(
        .EXP_W  (EXP_W),
        .MANT_W (MANT_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
`ifdef NORM_UF_FLAG_EN
        ,
        .out_uf    (out_uf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [EXP_W-1:0]  e;
        logic [MANT_W-1:0] m;
        logic [TAG_W-1:0]  t;
        logic              z;
        logic              u;
        int                cyc;
    } res_t;

    res_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_out   = 0;
    bit   acc     = 1'b0;
    bit   chk_lat = 1'b0;

    // Reference normalizer: count leading zeros, shift as far as the exponent allows
    function automatic res_t model(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                                   input logic [TAG_W-1:0] t);
        res_t r;
        int   lz;
        r.t   = t;
        r.cyc = 0;
        if (m == '0) begin
            r.e = e;
            r.m = m;
            r.z = 1'b1;
            r.u = 1'b0;
        end else begin
            lz = 0;
            while (m[MANT_W-1-lz] == 1'b0) lz++;
            r.z = 1'b0;
            if (int'(e) >= lz) begin
                r.m = m << lz;
                r.e = e - EXP_W'(lz);
                r.u = 1'b0;
            end else begin
                r.m = m << e;
                r.e = '0;
                r.u = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [MANT_W-1:0] rand_mant();
        logic [MANT_W-1:0] m;
        m = MANT_W'($urandom);
        m = m >> $urandom_range(0, MANT_W);
        return m;
    endfunction

    function automatic logic [EXP_W-1:0] rand_exp();
        if ($urandom_range(0, 1) == 1) return EXP_W'($urandom_range(0, 31));
        return EXP_W'($urandom_range(0, 255));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // One clock: check outputs against the scoreboard head, record input transfer
    task automatic cycle();
        res_t r;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                r = exp_q[0];
                chk("out_exp", 64'(out_exp), 64'(r.e));
                chk("out_mant", 64'(out_mant), 64'(r.m));
                chk("out_tag", 64'(out_tag), 64'(r.t));
                chk("out_zero", 64'(out_zero), 64'(r.z));
`ifdef NORM_UF_FLAG_EN
                chk("out_uf", 64'(out_uf), 64'(r.u));
`endif
                if (out_ready) begin
                    if (chk_lat) chk("latency", 64'(cyc - r.cyc), 64'd2);
                    $display("t=%0t out tag=%0h exp=%0h mant=%0h zero=%0b", $time,
                             out_tag, out_exp, out_mant, out_zero);
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (acc) begin
            r     = model(in_exp, in_mant, in_tag);
            r.cyc = cyc;
            exp_q.push_back(r);
            $display("t=%0t in  tag=%0h exp=%0h mant=%0h", $time, in_tag, in_exp, in_mant);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [EXP_W-1:0] e, input logic [MANT_W-1:0] m,
                        input logic [TAG_W-1:0] t);
        int budget;
        in_valid = 1'b1;
        in_exp   = e;
        in_mant  = m;
        in_tag   = t;
        budget   = 0;
        do begin
            cycle();
            budget++;
        end while (!acc && budget < 50);
        if (!acc) chk("send_timeout", 64'(budget), 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            cycle();
            budget++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [EXP_W-1:0]  bp_e [3];
        logic [MANT_W-1:0] bp_m [3];
        int idx;
        int budget;
        int n0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
`ifdef NORM_UF_FLAG_EN
        chk("rst_out_uf", 64'(out_uf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed: normal shift, equal boundary, clamp, zero, already normal
        chk_lat = 1'b1;
        send(8'h80, 28'h0800000, 4'h1);
        send(8'h04, 28'h0800000, 4'h2);
        send(8'h03, 28'h0000001, 4'h3);
        send(8'h55, 28'h0000000, 4'h4);
        send(8'h00, 28'h8000000, 4'h5);
        send(8'h00, 28'h0000001, 4'h6);
        send(8'hFF, 28'h0000001, 4'h7);
        drain();

        // Throughput: back-to-back random operands, latency exactly 2 each
        n0 = n_out;
        for (int i = 0; i < 10; i++) send(rand_exp(), rand_mant(), TAG_W'(i));
        drain();
        chk("tput_count", 64'(n_out - n0), 64'd10);
        chk_lat = 1'b0;

        // Backpressure: tags 1,2,3 with out_ready low for 4 cycles
        for (int i = 0; i < 3; i++) begin
            bp_e[i] = rand_exp();
            bp_m[i] = rand_mant();
        end
        n0        = n_out;
        out_ready = 1'b0;
        idx       = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_exp   = bp_e[idx];
            in_mant  = bp_m[idx];
            in_tag   = TAG_W'(idx + 1);
            cycle();
            if (acc) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        budget    = 0;
        while (idx < 3 && budget < 50) begin
            in_valid = 1'b1;
            in_exp   = bp_e[idx];
            in_mant  = bp_m[idx];
            in_tag   = TAG_W'(idx + 1);
            cycle();
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_count", 64'(n_out - n0), 64'd3);

        // Random valid/ready traffic
        n0     = n_out;
        idx    = 0;
        budget = 0;
        while ((idx < 20 || exp_q.size() > 0) && budget < 400) begin
            in_valid  = (idx < 20) && ($urandom_range(0, 3) != 0);
            in_exp    = rand_exp();
            in_mant   = rand_mant();
            in_tag    = TAG_W'(idx);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (acc) idx++;
            budget++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_count", 64'(n_out - n0), 64'd20);

        // Reset with two operands in flight
        out_ready = 1'b0;
        send(rand_exp(), rand_mant(), 4'hA);
        send(rand_exp(), rand_mant(), 4'hB);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_mant", 64'(out_mant), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        n0        = n_out;
        send(8'h10, 28'h0001234, 4'hC);
        drain();
        chk("post_rst_count", 64'(n_out - n0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalize_pipe.md
Name: normalize_pipe

Overview:
- Parametrised, pipelined successor to the combinational mantissa normalizer.
- Left-shifts a mantissa until its MSB is 1 and decrements the exponent by the shift amount.
- Clamps at exponent 0, producing a denormal result.
- Two-stage valid/ready pipeline with a sideband tag; sits between the add/sub align-and-sum stage and the rounder in the FP datapath.

Parameters:
- EXP_W, 8, exponent width in bits.
- MANT_W, 28, mantissa width in bits; MSB is the hidden-bit position after normalization.
- TAG_W, 4, width of the opaque sideband tag carried alongside each operand.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept the operand this cycle.
- in_exp  input  EXP_W  unnormalized exponent.
- in_mant  input  MANT_W  unnormalized mantissa.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_exp  output  EXP_W  normalized exponent.
- out_mant  output  MANT_W  normalized mantissa.
- out_tag  output  TAG_W  tag of this result.
- out_zero  output  1  input mantissa was all zeros.
- out_uf  output  1  exponent clamp occurred (only with NORM_UF_FLAG_EN).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all stage valids and out_valid are 0; out_exp, out_mant, out_tag, out_zero and out_uf are 0. in_ready reads 1 as soon as rst_n is high.
- Stage 1 (S1):
  - An input transfers when in_valid && in_ready.
  - Registers exp, mant and tag, plus lzc = leading-zero count of mant from the norm_lzc sub-module.
  - lzc is SH_W = clog2(MANT_W+1) bits wide. mant == 0 gives lzc = 0 and zero = 1.
- Stage 2 (S2):
  - Clamp comparison: compare the zero-extended exp against lzc.
  - If exp >= lzc: mant << lzc, exp - lzc, uf = 0.
  - Otherwise: mant << exp, exp = 0, uf = 1.
  - The equal case (exp == lzc) is a normal shift, with uf = 0.
  - Zero mantissa: mant and exp pass through unchanged, zero = 1, uf = 0.
  - Results are registered onto the out_* ports.
- Latency and throughput:
  - Latency is 2 cycles from input transfer to out_valid.
  - Throughput is 1 result per cycle when out_ready is held high.
- Handshake:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en. This is a combinational ready chain, with no skid buffer.
  - Results are never dropped or duplicated. Order is strictly preserved.
- Simultaneous events:
  - An output transfer and a new S1→S2 move in the same cycle is allowed; S2 is overwritten with the new result.
  - An S1 move and a new input capture in the same cycle is allowed.
- Stall: while out_valid && !out_ready, the out_* ports hold stable. At most 2 operands are in flight.
- Reset mid-operation: all in-flight operands are discarded, and out_valid falls immediately (asynchronously).

Optional Feature:
- Macro: NORM_UF_FLAG_EN.
- Defined: port out_uf exists and is registered in S2 as described under Behaviour. It signals an exponent clamp (denormal result), for use by the exception logic.
- Undefined: port out_uf and its logic are absent. All other outputs behave identically.

Decomposition:
- Package norm_pkg:
  - clog2 constant function.
  - Default width constants EXP_W_D=8 and MANT_W_D=28.
  - Packed struct typedef norm_op_t {exp, mant, tag} used for the stage registers.
- Sub-module norm_lzc:
  - Parametrised (MANT_W), purely combinational leading-zero counter.
  - Implemented as a nibble-grouped priority encoder producing SH_W bits, with zero input giving 0 and a zero flag.
  - Instantiated once, in S1.

Test Plan (EXP_W=8, MANT_W=28):
1. Normal shift:
   - exp=0x80, mant=0x0800000 → 2 cycles later exp=0x7C, mant=0x8000000, zero=0, uf=0.
   - exp=0x04, same mant → exp=0x00, mant=0x8000000, uf=0 (equal boundary).
2. Clamp: exp=0x03, mant=0x0000001 → exp=0x00, mant=0x0000008, uf=1.
3. Zero and already normal:
   - mant=0, exp=0x55 → mant=0, exp=0x55, zero=1.
   - mant=0x8000000, exp=0x00 → unchanged, uf=0.
4. Backpressure:
   - Stream tags 1,2,3 with out_ready=0 for 4 cycles → in_ready drops after 2 accepts; tag 3 waits; out_* are stable while stalled.
   - After out_ready=1, results 1,2,3 arrive in order with no duplicates.
5. Throughput: 10 back-to-back random operands with out_ready=1 → 10 results on consecutive cycles after 2-cycle latency, matching a golden model.
6. Reset:
   - Drop rst_n with 2 operands in flight → out_valid=0 immediately, with no clock edge needed.
   - After release, in_ready=1 and the first new operand returns correctly.
